controller: RTL and testbench
=============================

CONTROLLER -- requirements
Module: controller

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value driven during and after reset.
REQ-002 Parameter MEM_TIMEOUT, default 16, maximum cycles spent in MEM_WAIT before fault; range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 memory_done  input  1  memory/writeback stage completed its access this cycle.
REQ-006 pc_sel  input  `SEL_PC_WIDTH  next-PC source selected by decode_execute.
REQ-007 br_taken  input  1  branch condition result from decode_execute.
REQ-008 ir  input  32  instruction currently in decode_execute.
REQ-009 next_pc  input  32  next PC computed by fetch from c_pc_sel/c_br_taken.
REQ-010 c_fetch_stall  output  1  freeze fetch.
REQ-011 c_pc_sel  output  `SEL_PC_WIDTH  PC source forwarded to fetch.
REQ-012 c_br_taken  output  1  branch-taken forwarded to fetch.
REQ-013 c_next_pc  output  32  value the datapath PC register loads at the next edge.
REQ-014 halted  output  1  registered; ECALL/EBREAK retired.
REQ-015 fault  output  1  registered; illegal opcode, misaligned target or memory timeout.
REQ-016 cycle_count  output  32  registered; cycles since reset release.
REQ-017 instret_count  output  32  registered; retired instructions.

Function
REQ-018 FSM states SHALL be BOOT, RUN, MEM_WAIT, HALT, FAULT; internal pc_q SHALL mirror the datapath PC (loads c_next_pc every edge).
REQ-019 c_fetch_stall, c_pc_sel, c_br_taken, c_next_pc SHALL be combinational from state, pc_q and inputs (zero-latency path to the PC register).
REQ-020 Whenever stalled: c_fetch_stall=1, c_pc_sel=0, c_br_taken=0, c_next_pc=pc_q.
REQ-021 BOOT: stalled for exactly one cycle, then RUN.
REQ-022 RUN, ir opcode in {LUI, AUIPC, JAL, JALR, BRANCH, OP-IMM, OP, FENCE}: advance -- c_fetch_stall=0, c_pc_sel=pc_sel, c_br_taken=br_taken, c_next_pc=next_pc, instret_count+1.
REQ-023 RUN, opcode LOAD (7'b0000011) or STORE (7'b0100011): advance as REQ-022 if memory_done=1 the same cycle; otherwise stall, go MEM_WAIT, wait counter cleared.
REQ-024 MEM_WAIT: stalled, wait counter+1 per cycle; on memory_done=1 advance as REQ-022 and return to RUN.
REQ-025 MEM_WAIT: when wait counter reaches MEM_TIMEOUT with memory_done=0, go FAULT; memory_done on that same cycle wins (advance).
REQ-026 RUN, ir==32'h0000_0073 or 32'h0010_0073: stall, go HALT, instret_count+1; other SYSTEM encodings and unlisted opcodes: stall, go FAULT, no retire.
REQ-027 Any advance whose next_pc[1:0]!=2'b00: stall instead, go FAULT, no retire.
REQ-028 HALT and FAULT SHALL be terminal until rst; halted=1 only in HALT, fault=1 only in FAULT.
REQ-029 cycle_count SHALL increment every non-reset cycle including BOOT/HALT/FAULT; both counters wrap modulo 2^32.

Reset
REQ-030 While rst=1: state BOOT, pc_q=RESET_PC, c_next_pc=RESET_PC, c_fetch_stall=1, c_pc_sel=0, c_br_taken=0, halted=0, fault=0, counters=0, wait counter=0.
REQ-031 rst asserted in any state, including mid-MEM_WAIT, SHALL abandon the access and apply REQ-030 at the next edge.

Verification
REQ-032 rst=1 3 cycles -> c_next_pc=0, stall=1, counters 0; release -> 1 BOOT cycle stall=1, then RUN, cycle_count=1 after first edge.
REQ-033 RUN, pc_q=0, ir=32'h0010_0093 (ADDI), next_pc=4 -> same cycle stall=0, c_next_pc=4; next cycle pc_q=4, instret_count=1.
REQ-034 ir=32'h0000_2083 (LW), memory_done low 3 cycles then high -> stall=1 and c_next_pc=pc_q for 3 cycles, 4th cycle c_next_pc=next_pc, instret+1.
REQ-035 STORE with memory_done held low, MEM_TIMEOUT=16 -> FAULT after 16 wait cycles, fault=1, PC frozen; done at 16th cycle instead -> advance.
REQ-036 BRANCH br_taken=1, next_pc=32'h40 -> c_br_taken=1, c_next_pc=32'h40; repeat with next_pc=32'h42 -> FAULT, c_next_pc=pc_q.
REQ-037 ir=32'h0000_0073 -> halted=1 next cycle, PC frozen, cycle_count still counting; rst during HALT -> REQ-030 values.

Source files
------------

// File: rtl/controller.sv
// Control FSM for a multicycle RV32 core: sequences fetch stalls, memory waits,
// halt/fault detection and retire/cycle counters. PC steering outputs are combinational.
`ifndef SEL_PC_WIDTH
`define SEL_PC_WIDTH 2
`endif

module controller #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     memory_done,
  input  logic [`SEL_PC_WIDTH-1:0] pc_sel,
  input  logic                     br_taken,
  input  logic [31:0]              ir,
  input  logic [31:0]              next_pc,
  output logic                     c_fetch_stall,
  output logic [`SEL_PC_WIDTH-1:0] c_pc_sel,
  output logic                     c_br_taken,
  output logic [31:0]              c_next_pc,
  output logic                     halted,
  output logic                     fault,
  output logic [31:0]              cycle_count,
  output logic [31:0]              instret_count
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [31:0] ECALL    = 32'h0000_0073;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;
  localparam logic [7:0]  TIMEOUT  = 8'(MEM_TIMEOUT);

  typedef enum logic [2:0] {BOOT, RUN, MEM_WAIT, HALT, FAULT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q;
  logic [7:0]  wait_q, wait_d;
  logic        halted_q, fault_q;
  logic [31:0] cycle_q, instret_q;
  logic        retire;
  logic        adv;
  logic [7:0]  wait_inc;

  assign wait_inc = wait_q + 8'd1;

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    c_fetch_stall = 1'b1;
    c_pc_sel      = '0;
    c_br_taken    = 1'b0;
    c_next_pc     = pc_q;
    retire        = 1'b0;
    adv           = 1'b0;

    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        case (ir[6:0])
          OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
          OP_BRANCH, OP_IMM, OP_OP, OP_FENCE: adv = 1'b1;
          OP_LOAD, OP_STORE: begin
            if (memory_done) begin
              adv = 1'b1;
            end else begin
              state_d = MEM_WAIT;
              wait_d  = '0;
            end
          end
          default: begin
            if (ir == ECALL || ir == EBREAK) begin
              state_d = HALT;
              retire  = 1'b1;
            end else begin
              state_d = FAULT;
            end
          end
        endcase
      end
      MEM_WAIT: begin
        // A completion arriving on the timeout cycle still counts as success.
        if (memory_done) begin
          adv = 1'b1;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == TIMEOUT) state_d = FAULT;
        end
      end
      HALT:    state_d = HALT;
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase

    if (adv) begin
      if (next_pc[1:0] != 2'b00) begin
        state_d = FAULT;
      end else begin
        state_d       = RUN;
        c_fetch_stall = 1'b0;
        c_pc_sel      = pc_sel;
        c_br_taken    = br_taken;
        c_next_pc     = next_pc;
        retire        = 1'b1;
      end
    end

    if (rst) begin
      state_d       = BOOT;
      wait_d        = '0;
      c_fetch_stall = 1'b1;
      c_pc_sel      = '0;
      c_br_taken    = 1'b0;
      c_next_pc     = RESET_PC;
      retire        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      wait_q    <= '0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= c_next_pc;
      wait_q    <= wait_d;
      halted_q  <= (state_d == HALT);
      fault_q   <= (state_d == FAULT);
      cycle_q   <= cycle_q + 32'd1;
      if (retire) instret_q <= instret_q + 32'd1;
    end
  end

  assign halted        = halted_q;
  assign fault         = fault_q;
  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;

endmodule

// File: tb/tb_controller.sv
// Bench for controller: directed literal scenarios, then randomized traffic
// checked every cycle against an instruction-level reference model.
`ifndef SEL_PC_WIDTH
`define SEL_PC_WIDTH 2
`endif

module tb_controller;

  localparam int          SW       = `SEL_PC_WIDTH;
  localparam int          TO       = 16;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] ADDI     = 32'h0010_0093;
  localparam logic [31:0] LW       = 32'h0000_2083;
  localparam logic [31:0] SW_I     = 32'h0000_2023;
  localparam logic [31:0] BEQ      = 32'h0000_0063;
  localparam logic [31:0] ECALL_I  = 32'h0000_0073;

  localparam int BOOTING = 0;
  localparam int RUNNING = 1;
  localparam int HALTED  = 2;
  localparam int DEAD    = 3;

  bit              clk = 1'b0;
  logic            rst = 1'b1;
  logic            memory_done = 1'b0;
  logic [SW-1:0]   pc_sel = '0;
  logic            br_taken = 1'b0;
  logic [31:0]     ir = ADDI;
  logic [31:0]     next_pc = '0;
  logic            c_fetch_stall;
  logic [SW-1:0]   c_pc_sel;
  logic            c_br_taken;
  logic [31:0]     c_next_pc;
  logic            halted;
  logic            fault;
  logic [31:0]     cycle_count;
  logic [31:0]     instret_count;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Reference model: architectural view of the core (mode, PC, counters, pending access).
  int          m_mode   = BOOTING;
  bit          m_in_mem = 1'b0;
  int          m_age    = 0;
  logic [31:0] m_pc     = RESET_PC;
  logic [31:0] m_cyc    = '0;
  logic [31:0] m_inst   = '0;

  controller #(.RESET_PC(RESET_PC), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .memory_done(memory_done), .pc_sel(pc_sel),
    .br_taken(br_taken), .ir(ir), .next_pc(next_pc),
    .c_fetch_stall(c_fetch_stall), .c_pc_sel(c_pc_sel), .c_br_taken(c_br_taken),
    .c_next_pc(c_next_pc), .halted(halted), .fault(fault),
    .cycle_count(cycle_count), .instret_count(instret_count)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // 0: always retires, 1: memory access, 2: ECALL/EBREAK, 3: illegal
  function automatic int cls(input logic [31:0] i);
    case (i[6:0])
      7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h13, 7'h33, 7'h0f: return 0;
      7'h03, 7'h23: return 1;
      default: return (i == 32'h0000_0073 || i == 32'h0010_0073) ? 2 : 3;
    endcase
  endfunction

  always begin : scoreboard
    logic          e_stall, e_bt;
    logic [SW-1:0] e_sel;
    logic [31:0]   e_npc;
    int            n_mode, n_age;
    bit            n_mem, retire, go;
    @(negedge clk);
    e_stall = 1'b1; e_sel = '0; e_bt = 1'b0; e_npc = m_pc;
    n_mode = m_mode; n_mem = m_in_mem; n_age = m_age; retire = 1'b0; go = 1'b0;
    if (rst) begin
      n_mode = BOOTING; n_mem = 1'b0; n_age = 0; e_npc = RESET_PC;
    end else if (m_mode == BOOTING) begin
      n_mode = RUNNING;
    end else if (m_mode == RUNNING) begin
      if (m_in_mem) begin
        if (memory_done) go = 1'b1;
        else begin
          n_age = m_age + 1;
          if (n_age >= TO) begin n_mode = DEAD; n_mem = 1'b0; end
        end
      end else begin
        case (cls(ir))
          0: go = 1'b1;
          1: if (memory_done) go = 1'b1; else begin n_mem = 1'b1; n_age = 0; end
          2: begin n_mode = HALTED; retire = 1'b1; end
          default: n_mode = DEAD;
        endcase
      end
    end
    if (go) begin
      n_mem = 1'b0;
      if (next_pc[1:0] != 2'b00) n_mode = DEAD;
      else begin
        e_stall = 1'b0; e_sel = pc_sel; e_bt = br_taken; e_npc = next_pc; retire = 1'b1;
      end
    end
    if (chk_en) begin
      chk("m_stall",   32'(c_fetch_stall), 32'(e_stall));
      chk("m_pc_sel",  32'(c_pc_sel),      32'(e_sel));
      chk("m_br",      32'(c_br_taken),    32'(e_bt));
      chk("m_next_pc", c_next_pc,          e_npc);
      chk("m_halted",  32'(halted),        32'(m_mode == HALTED));
      chk("m_fault",   32'(fault),         32'(m_mode == DEAD));
      chk("m_cycle",   cycle_count,        m_cyc);
      chk("m_instret", instret_count,      m_inst);
    end
    @(posedge clk);
    m_mode = n_mode; m_in_mem = n_mem; m_age = n_age; m_pc = e_npc;
    m_cyc  = rst ? 32'd0 : m_cyc + 32'd1;
    m_inst = rst ? 32'd0 : m_inst + 32'(retire);
  end

  task automatic drv(input logic r, input logic d, input logic [SW-1:0] s,
                     input logic b, input logic [31:0] i, input logic [31:0] np);
    @(posedge clk); #1;
    rst = r; memory_done = d; pc_sel = s; br_taken = b; ir = i; next_pc = np;
  endtask

  task automatic look();
    @(negedge clk); #1;
  endtask

  initial begin
    int dprob, idle;
    logic [31:0] r, x;
    logic [6:0]  ops [8];
    ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h13, 7'h33, 7'h0f};
    dprob = 35; idle = 0;

    drv(1, 0, '0, 0, ADDI, 0);
    chk_en = 1'b1;
    repeat (2) drv(1, 0, '0, 0, ADDI, 0);
    look();
    chk("rst_next_pc", c_next_pc, 32'h0);
    chk("rst_stall", 32'(c_fetch_stall), 32'd1);
    chk("rst_cycle", cycle_count, 32'd0);
    chk("rst_flags", 32'({halted, fault}), 32'd0);

    drv(0, 0, SW'(1), 0, ADDI, 32'h4);
    look();
    chk("boot_stall", 32'(c_fetch_stall), 32'd1);
    chk("boot_next_pc", c_next_pc, 32'h0);
    drv(0, 0, SW'(1), 0, ADDI, 32'h4);
    look();
    chk("addi_stall", 32'(c_fetch_stall), 32'd0);
    chk("addi_next_pc", c_next_pc, 32'h4);
    chk("addi_cycle", cycle_count, 32'd1);

    drv(0, 0, '0, 0, LW, 32'h8);
    look();
    chk("lw_instret", instret_count, 32'd1);
    chk("lw_stall", 32'(c_fetch_stall), 32'd1);
    chk("lw_hold_pc", c_next_pc, 32'h4);
    repeat (2) begin
      drv(0, 0, '0, 0, LW, 32'h8);
      look();
      chk("lw_wait_pc", c_next_pc, 32'h4);
    end
    drv(0, 1, '0, 0, LW, 32'h8);
    look();
    chk("lw_done_stall", 32'(c_fetch_stall), 32'd0);
    chk("lw_done_pc", c_next_pc, 32'h8);

    drv(0, 0, SW'(2), 1, BEQ, 32'h40);
    look();
    chk("br_taken", 32'(c_br_taken), 32'd1);
    chk("br_next_pc", c_next_pc, 32'h40);
    chk("br_instret", instret_count, 32'd2);
    drv(0, 0, SW'(2), 1, BEQ, 32'h42);
    look();
    chk("mis_stall", 32'(c_fetch_stall), 32'd1);
    chk("mis_next_pc", c_next_pc, 32'h40);
    drv(0, 0, SW'(2), 1, BEQ, 32'h44);
    look();
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_instret", instret_count, 32'd3);

    // Store never completes: sixteen wait cycles then fault.
    drv(1, 0, '0, 0, SW_I, 32'h4);
    drv(0, 0, '0, 0, SW_I, 32'h4);
    drv(0, 0, '0, 0, SW_I, 32'h4);
    repeat (TO) begin
      drv(0, 0, '0, 0, SW_I, 32'h4);
      look();
      chk("to_no_fault_yet", 32'(fault), 32'd0);
    end
    drv(0, 1, '0, 0, SW_I, 32'h4);
    look();
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_pc_frozen", c_next_pc, 32'h0);

    // Completion on the last allowed wait cycle advances instead.
    drv(1, 0, '0, 0, SW_I, 32'h4);
    drv(0, 0, '0, 0, SW_I, 32'h4);
    drv(0, 0, '0, 0, SW_I, 32'h4);
    repeat (TO - 1) drv(0, 0, '0, 0, SW_I, 32'h4);
    drv(0, 1, '0, 0, SW_I, 32'h4);
    look();
    chk("to16_stall", 32'(c_fetch_stall), 32'd0);
    chk("to16_next_pc", c_next_pc, 32'h4);

    drv(0, 0, '0, 0, ECALL_I, 32'h8);
    look();
    chk("ecall_stall", 32'(c_fetch_stall), 32'd1);
    chk("ecall_cycle", cycle_count, 32'd18);
    drv(0, 1, '0, 0, ECALL_I, 32'h8);
    look();
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_instret", instret_count, 32'd2);
    chk("halt_pc", c_next_pc, 32'h4);
    drv(0, 1, '0, 0, ADDI, 32'h8);
    look();
    chk("halt_cycle", cycle_count, 32'd20);
    chk("halt_terminal", 32'(halted), 32'd1);
    drv(1, 0, '0, 0, ADDI, 32'h8);
    look();
    chk("hrst_next_pc", c_next_pc, 32'h0);
    drv(1, 0, '0, 0, ADDI, 32'h8);
    look();
    chk("hrst_halted", 32'(halted), 32'd0);
    chk("hrst_counters", cycle_count | instret_count, 32'd0);

    for (int n = 0; n < 4000; n++) begin
      logic rr;
      logic [6:0] op;
      logic [31:0] i_w, np_w;
      idle = (m_mode == HALTED || m_mode == DEAD) ? idle + 1 : 0;
      rr = ($urandom_range(0, 59) == 0) || (idle > 4);
      if (rr) begin
        case ($urandom_range(0, 2))
          0: dprob = 5;
          1: dprob = 35;
          default: dprob = 75;
        endcase
      end
      r = $urandom();
      x = $urandom();
      case ($urandom_range(0, 19))
        10, 11, 12, 13, 14: op = r[0] ? 7'h03 : 7'h23;
        15: op = 7'h73;
        16: op = 7'h73;
        17: op = r[6:0];
        default: op = ops[$urandom_range(0, 7)];
      endcase
      i_w = {r[31:7], op};
      if (op == 7'h73 && r[3]) i_w = r[4] ? 32'h0010_0073 : 32'h0000_0073;
      np_w = {x[31:2], 2'b00};
      if ($urandom_range(0, 15) == 0) np_w[1:0] = 2'($urandom_range(1, 3));
      drv(rr, ($urandom_range(0, 99) < dprob), SW'($urandom()), 1'($urandom()), i_w, np_w);
    end
    drv(0, 0, '0, 0, ADDI, 32'h0);
    look();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
